// File: rtl/galaxian_pkg.sv
// Shared keycode constants, pilot state codes and LFSR step for galaxian blocks.
package galaxian_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef logic [2:0] pilot_state_t;

  localparam pilot_state_t ST_WAIT   = 3'd0;
  localparam pilot_state_t ST_CHOOSE = 3'd1;
  localparam pilot_state_t ST_MOVE_L = 3'd2;
  localparam pilot_state_t ST_MOVE_R = 3'd3;
  localparam pilot_state_t ST_HOLD   = 3'd4;
  localparam pilot_state_t ST_FIRE   = 3'd5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit right-shift Galois LFSR; a zero seed is coerced to 1.
module lfsr16
  import galaxian_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] init;

  assign init = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= init;
    else       q <= lfsr_step(q);
  end

endmodule

// File: rtl/attract_pilot.sv
// Attract-mode keycode source: pseudo-random pilot until a user key arrives.
// Define ATTRACT_FIRE_EN to compile in the FIRE action.
module attract_pilot
  import galaxian_pkg::*;
#(
  parameter int unsigned IDLE_FRAMES = 600,
  parameter int unsigned MOVE_MIN    = 16,
  parameter logic [7:0]  MOVE_MASK   = 8'h3F,
  parameter int unsigned X_GUARD_LO  = 40,
  parameter int unsigned X_GUARD_HI  = 600,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       attract_en,
  input  logic [7:0] user_keycode,
  input  logic [9:0] PlayerX,
  output logic [7:0] keycode,
  output logic       demo_active
);

  localparam int unsigned IDLE_LAST_I = IDLE_FRAMES - 1;
  localparam logic [15:0] IDLE_LAST   = IDLE_LAST_I[15:0];
  localparam logic [7:0]  DUR_MIN     = MOVE_MIN[7:0];
  localparam logic [9:0]  GUARD_LO    = X_GUARD_LO[9:0];
  localparam logic [9:0]  GUARD_HI    = X_GUARD_HI[9:0];

  pilot_state_t state, state_n;
  logic [15:0]  idle_cnt, idle_n;
  logic [7:0]   dur_cnt, dur_n;
  logic [7:0]   key_n;
  logic         demo_n;
  logic [15:0]  lfsr;
  logic         takeover;

  lfsr16 u_lfsr (
    .clk   (frame_clk),
    .reset (Reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign takeover = (user_keycode != KEY_NONE) || !attract_en;

`ifdef ATTRACT_FIRE_EN
  logic fire_phase, phase_n;
`endif

  always_comb begin
    state_n = state;
    idle_n  = idle_cnt;
    dur_n   = dur_cnt;
    key_n   = KEY_NONE;
    demo_n  = 1'b1;
`ifdef ATTRACT_FIRE_EN
    phase_n = fire_phase;
`endif
    if (takeover) begin
      state_n = ST_WAIT;
      idle_n  = 16'd0;
      key_n   = user_keycode;
      demo_n  = 1'b0;
    end else begin
      unique case (state)
        ST_WAIT: begin
          key_n  = user_keycode;
          demo_n = 1'b0;
          if (idle_cnt == IDLE_LAST) begin
            state_n = ST_CHOOSE;
            demo_n  = 1'b1;
          end else begin
            idle_n = idle_cnt + 16'd1;
          end
        end
        ST_CHOOSE: begin
          dur_n = DUR_MIN + (lfsr[15:8] & MOVE_MASK);
          unique case (lfsr[1:0])
            2'b00: begin
              state_n = ST_MOVE_L;
              key_n   = KEY_A;
            end
            2'b01: begin
              state_n = ST_MOVE_R;
              key_n   = KEY_D;
            end
            2'b10: state_n = ST_HOLD;
            2'b11: begin
`ifdef ATTRACT_FIRE_EN
              state_n = ST_FIRE;
              key_n   = KEY_SPACE;
              phase_n = 1'b0;
`else
              state_n = ST_HOLD;
`endif
            end
          endcase
        end
        ST_MOVE_L: begin
          // Guard beats expiry so the ship never pins against an edge.
          if (PlayerX <= GUARD_LO) begin
            state_n = ST_MOVE_R;
            key_n   = KEY_D;
          end else if (dur_cnt == 8'd0) begin
            state_n = ST_CHOOSE;
          end else begin
            dur_n = dur_cnt - 8'd1;
            key_n = KEY_A;
          end
        end
        ST_MOVE_R: begin
          if (PlayerX >= GUARD_HI) begin
            state_n = ST_MOVE_L;
            key_n   = KEY_A;
          end else if (dur_cnt == 8'd0) begin
            state_n = ST_CHOOSE;
          end else begin
            dur_n = dur_cnt - 8'd1;
            key_n = KEY_D;
          end
        end
        ST_HOLD: begin
          if (dur_cnt == 8'd0) state_n = ST_CHOOSE;
          else                 dur_n   = dur_cnt - 8'd1;
        end
`ifdef ATTRACT_FIRE_EN
        ST_FIRE: begin
          if (dur_cnt == 8'd0) begin
            state_n = ST_CHOOSE;
          end else begin
            dur_n   = dur_cnt - 8'd1;
            key_n   = fire_phase ? KEY_SPACE : KEY_NONE;
            phase_n = ~fire_phase;
          end
        end
`endif
        default: begin
          state_n = ST_WAIT;
          idle_n  = 16'd0;
          demo_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_WAIT;
      idle_cnt    <= 16'd0;
      dur_cnt     <= 8'd0;
      keycode     <= KEY_NONE;
      demo_active <= 1'b0;
    end else begin
      state       <= state_n;
      idle_cnt    <= idle_n;
      dur_cnt     <= dur_n;
      keycode     <= key_n;
      demo_active <= demo_n;
    end
  end

`ifdef ATTRACT_FIRE_EN
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) fire_phase <= 1'b0;
    else       fire_phase <= phase_n;
  end
`endif

endmodule

// File: tb/tb_attract_pilot.sv
// Randomized bench for attract_pilot against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_attract_pilot;

  localparam int IDLE = 4;
  localparam int MMIN = 16;
  localparam int MASK = 'h3F;
`ifdef ATTRACT_FIRE_EN
  localparam bit FIRE_ON = 1'b1;
`else
  localparam bit FIRE_ON = 1'b0;
`endif

  localparam int MI = 0;
  localparam int MC = 1;
  localparam int ML = 2;
  localparam int MR = 3;
  localparam int MH = 4;
  localparam int MF = 5;

  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       attract_en = 1'b1;
  logic [7:0] user_keycode = 8'h00;
  logic [9:0] PlayerX = 10'd300;
  logic [7:0] keycode, keycode0;
  logic       demo_active, demo0;

  attract_pilot #(.IDLE_FRAMES(IDLE)) dut (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .attract_en   (attract_en),
    .user_keycode (user_keycode),
    .PlayerX      (PlayerX),
    .keycode      (keycode),
    .demo_active  (demo_active)
  );

  attract_pilot #(.IDLE_FRAMES(IDLE), .LFSR_SEED(16'h0000)) dut0 (
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .attract_en   (attract_en),
    .user_keycode (user_keycode),
    .PlayerX      (PlayerX),
    .keycode      (keycode0),
    .demo_active  (demo0)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0;
  int checks = 0;

  int          m_mode, m_idle, m_rem;
  bit          m_last_fire, m_demo;
  logic [7:0]  m_key;
  logic [15:0] m_lfsr, m0_lfsr;
  int          edges;
  int          first_return;
  int          fire_seen;
  logic [7:0]  prev_key;
  bit          prev_demo;
  logic [9:0]  xedge [8] = '{10'd0, 10'd39, 10'd40, 10'd41,
                              10'd599, 10'd600, 10'd601, 10'd1023};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    int v;
    v = int'(x);
    v = (v / 2) ^ ((v % 2) * 'hB400);
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_mode = MI; m_idle = 0; m_rem = 0; m_last_fire = 0;
    m_demo = 0; m_key = 8'h00;
    m_lfsr = 16'hACE1; m0_lfsr = 16'h0001;
    edges = 0; first_return = -1;
    prev_key = 8'h00; prev_demo = 0;
  endtask

  task automatic model_step();
    logic [15:0] cur;
    int pick;
    cur = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m0_lfsr = lfsr_next(m0_lfsr);
    if (user_keycode != 8'h00 || !attract_en) begin
      m_mode = MI; m_idle = 0; m_key = user_keycode; m_demo = 0;
      return;
    end
    m_demo = 1;
    m_key = 8'h00;
    case (m_mode)
      MI: begin
        m_demo = 0;
        m_key = user_keycode;
        if (m_idle + 1 == IDLE) begin
          m_mode = MC; m_demo = 1;
        end else m_idle++;
      end
      MC: begin
        m_rem = (MMIN + ((int'(cur) / 256) & MASK)) % 256;
        pick = int'(cur) % 4;
        if (pick == 3 && !FIRE_ON) pick = 2;
        case (pick)
          0: begin m_mode = ML; m_key = 8'h04; end
          1: begin m_mode = MR; m_key = 8'h07; end
          2: m_mode = MH;
          default: begin m_mode = MF; m_key = 8'h2C; m_last_fire = 1; end
        endcase
      end
      ML: begin
        if (PlayerX <= 40) begin m_mode = MR; m_key = 8'h07; end
        else if (m_rem == 0) m_mode = MC;
        else begin m_rem--; m_key = 8'h04; end
      end
      MR: begin
        if (PlayerX >= 600) begin m_mode = ML; m_key = 8'h04; end
        else if (m_rem == 0) m_mode = MC;
        else begin m_rem--; m_key = 8'h07; end
      end
      MH: begin
        if (m_rem == 0) m_mode = MC;
        else m_rem--;
      end
      default: begin
        if (m_rem == 0) m_mode = MC;
        else begin
          m_rem--;
          m_key = m_last_fire ? 8'h00 : 8'h2C;
          m_last_fire = !m_last_fire;
        end
      end
    endcase
  endtask

  task automatic compare();
    chk("keycode", keycode, m_key);
    chk("demo_active", demo_active, m_demo);
    chk("lfsr", dut.lfsr, m_lfsr);
    chk("lfsr_nonzero", dut.lfsr != 16'h0000, 1);
    chk("lfsr_seed0", dut0.lfsr, m0_lfsr);
    chk("dur_cnt", dut.dur_cnt, m_rem);
    if (demo_active && keycode == 8'h2C) begin
      fire_seen++;
      chk("fire_gap", prev_demo && prev_key == 8'h2C, 0);
    end
    if (!FIRE_ON && demo_active)
      chk("no_fire", keycode == 8'h2C, 0);
    if (first_return < 0 && dut.lfsr == 16'hACE1)
      first_return = edges;
    prev_key = keycode;
    prev_demo = demo_active;
  endtask

  task automatic cycle();
    @(posedge frame_clk);
    model_step();
    edges++;
    @(negedge frame_clk);
    compare();
  endtask

  task automatic rand_x();
    if ($urandom_range(7) == 0) PlayerX = xedge[$urandom_range(7)];
    else PlayerX = 10'($urandom_range(599, 41));
  endtask

  task automatic wait_left(output bit ok);
    ok = 0;
    user_keycode = 8'h00; attract_en = 1'b1; PlayerX = 10'd300;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (m_mode == ML && m_rem > 2) begin ok = 1; break; end
    end
    if (!ok) chk("wait_move_l_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    int saved, n;
    logic [7:0] last_user;

    model_reset();
    #12;
    chk("reset_keycode", keycode, 8'h00);
    chk("reset_demo", demo_active, 0);
    chk("reset_lfsr", dut.lfsr, 16'hACE1);
    chk("reset_dur", dut.dur_cnt, 0);
    chk("reset_seed0_lfsr", dut0.lfsr, 16'h0001);
    chk("reset_seed0_key", keycode0, 8'h00);
    chk("reset_seed0_demo", demo0, 0);
    Reset = 1'b0;

    for (int i = 1; i <= IDLE; i++) begin
      cycle();
      if (i == 1) chk("lfsr_edge1", dut.lfsr, 16'hE270);
      if (i < IDLE) chk("idle_demo_low", demo_active, 0);
    end
    chk("start_demo", demo_active, 1);
    chk("start_key", keycode, 8'h00);

    attract_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      user_keycode = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      last_user = user_keycode;
      rand_x();
      cycle();
      chk("passthru_key", keycode, last_user);
      chk("passthru_demo", demo_active, 0);
    end

    attract_en = 1'b1;
    user_keycode = 8'h00;
    fire_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      rand_x();
      cycle();
    end
    if (FIRE_ON) chk("fire_seen", fire_seen > 0, 1);
    else         chk("fire_seen", fire_seen, 0);

    wait_left(ok);
    if (ok) begin
      user_keycode = 8'h07;
      cycle();
      chk("takeover_key", keycode, 8'h07);
      chk("takeover_demo", demo_active, 0);
      user_keycode = 8'h00;
      n = 0;
      for (int i = 0; i < 20 && !demo_active; i++) begin
        cycle();
        n++;
      end
      chk("resume_latency", n, IDLE);
    end

    wait_left(ok);
    if (ok) begin
      saved = m_rem;
      PlayerX = 10'd40;
      cycle();
      chk("guard_lo_key", keycode, 8'h07);
      chk("guard_lo_dur", dut.dur_cnt, saved);
      PlayerX = 10'd600;
      cycle();
      chk("guard_hi_key", keycode, 8'h04);
    end

    while (edges < 66000) begin
      n = $urandom_range(9);
      if (n < 6) begin
        user_keycode = 8'h00; attract_en = 1'b1;
        repeat ($urandom_range(200, 1)) begin rand_x(); cycle(); end
      end else if (n < 9) begin
        attract_en = 1'b1;
        repeat ($urandom_range(5, 1)) begin
          user_keycode = ($urandom_range(2) == 0) ? 8'h00 : 8'($urandom);
          rand_x();
          cycle();
        end
      end else begin
        attract_en = 1'b0; user_keycode = 8'h00;
        repeat ($urandom_range(10, 1)) cycle();
      end
    end
    chk("lfsr_period", first_return, 65535);

    wait_left(ok);
    #2 Reset = 1'b1;
    #1;
    chk("areset_key", keycode, 8'h00);
    chk("areset_demo", demo_active, 0);
    chk("areset_lfsr", dut.lfsr, 16'hACE1);
    chk("areset_dur", dut.dur_cnt, 0);
    Reset = 1'b0;
    model_reset();
    user_keycode = 8'h00; attract_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_x();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/attract_pilot.md
# attract_pilot

Autonomous keycode source for attract/demo mode. Sits between the USB keyboard keycode path and the player block. It sources the same 8-bit keycode stream the player consumes (0x04 left, 0x07 right, 0x2C fire, 0x00 none) from a pseudo-random pilot while no human input is present. It hands control back to the keyboard on the first nonzero user keycode.

## Interface
- IDLE_FRAMES, 600: frames of zero user input (and attract_en high) before the pilot takes over; range 1..65535.
- MOVE_MIN, 16: minimum duration of a pilot action, in frames.
- MOVE_MASK, 8'h3F: mask applied to the random duration extension; MOVE_MIN + MOVE_MASK ≤ 255.
- X_GUARD_LO, 40: PlayerX at or below this value forces a left move to become right.
- X_GUARD_HI, 600: PlayerX at or above this value forces a right move to become left.
- LFSR_SEED, 16'hACE1: LFSR reset value; a value of 0 is coerced to 16'h0001.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  clock, one edge per video frame.
- attract_en  in  1  pilot permitted; low forces pass-through.
- user_keycode  in  8  keycode from the keyboard interface.
- PlayerX  in  10  current player X position, unsigned.
- keycode  out  8  keycode delivered to the player block.
- demo_active  out  1  high while the pilot owns keycode.

## Operation
- Reset values: state WAIT, idle_cnt 0, dur_cnt 0, lfsr LFSR_SEED, keycode 8'h00, demo_active 0, fire_phase 0.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts right on every frame_clk edge regardless of state. It is never zero; period is 65535.
- Takeover has highest priority, in every state. If user_keycode ≠ 0 or attract_en = 0, then:
  - next state is WAIT;
  - idle_cnt is cleared to 0;
  - demo_active is cleared to 0;
  - keycode is loaded from user_keycode.
- WAIT:
  - keycode is loaded from user_keycode (pass-through, one-frame latency).
  - If idle_cnt = IDLE_FRAMES−1, go to CHOOSE; otherwise increment idle_cnt (16-bit).
- CHOOSE (one frame):
  - keycode 8'h00, demo_active 1.
  - dur_cnt is loaded with MOVE_MIN + (lfsr[15:8] & MOVE_MASK), 8-bit arithmetic.
  - Next state is selected by lfsr[1:0]: 00 MOVE_L, 01 MOVE_R, 10 HOLD, 11 FIRE.
- MOVE_L:
  - keycode 8'h04.
  - If PlayerX ≤ X_GUARD_LO, go to MOVE_R with dur_cnt unchanged.
  - Else if dur_cnt = 0, go to CHOOSE.
  - Else decrement dur_cnt.
- MOVE_R: mirror of MOVE_L, using keycode 8'h07 and the condition PlayerX ≥ X_GUARD_HI.
- HOLD: keycode 8'h00; decrement dur_cnt; go to CHOOSE when dur_cnt = 0.
- FIRE:
  - keycode alternates 8'h2C and 8'h00 on successive frames, starting with 8'h2C (fire_phase toggles). 8'h2C never appears on two consecutive frames.
  - dur_cnt handling is the same as HOLD.
  - fire_phase is cleared when FIRE is entered.
- Guard precedence: in MOVE_L/MOVE_R, the guard check wins over dur_cnt expiry on the same frame.
- demo_active stays 1 in CHOOSE, MOVE_L, MOVE_R, HOLD and FIRE.

## Timing
- All outputs are registered on frame_clk. keycode and demo_active reflect the state entered at the same edge.
- User input latency is 1 frame in every state: a keycode sampled at edge N appears after edge N.
- Pilot start: the CHOOSE state is entered at the IDLE_FRAMES-th edge after the last nonzero user keycode or after attract_en rises.
- An asynchronous Reset mid-action returns all registers to their reset values immediately; no partial action resumes.

## Configuration
- ATTRACT_FIRE_EN defined: FIRE state is compiled in, and lfsr[1:0] = 11 selects FIRE.
- ATTRACT_FIRE_EN undefined: FIRE state and fire_phase are removed, lfsr[1:0] = 11 selects HOLD, and 8'h2C can reach keycode only via user pass-through.

## Structure
- galaxian_pkg holds:
  - keycode constants KEY_NONE 8'h00, KEY_A 8'h04, KEY_D 8'h07, KEY_SPACE 8'h2C;
  - the pilot state enum (WAIT, CHOOSE, MOVE_L, MOVE_R, HOLD, FIRE).
- Sub-module lfsr16 (ports: clk, reset, seed, q[15:0]) provides the Galois LFSR; everything else lives in attract_pilot.

## Test plan
- IDLE_FRAMES=4, attract_en=1, user_keycode=0 from reset -> demo_active=0 after edges 1–3, demo_active=1 and keycode=8'h00 after edge 4.
- Pilot in MOVE_L, user_keycode=8'h07 at edge N -> after edge N keycode=8'h07 and demo_active=0; then user_keycode=0 -> demo_active returns 1 exactly IDLE_FRAMES edges later.
- Pilot in MOVE_L, PlayerX=40 -> next edge keycode=8'h07 and dur_cnt unchanged. Pilot in MOVE_R, PlayerX=600 -> next edge keycode=8'h04.
- attract_en=0 with a random user_keycode stream over 1000 frames -> keycode equals user_keycode delayed by one frame; demo_active always 0.
- LFSR seeded 16'hACE1 -> nonzero on every frame and returns to 16'hACE1 after exactly 65535 edges. With LFSR_SEED=0 -> starts at 16'h0001.
- 10000 idle frames with ATTRACT_FIRE_EN defined -> 8'h2C appears and never on consecutive frames. With ATTRACT_FIRE_EN undefined -> 8'h2C never appears.
